nlfsr_tap_enumerator: RTL and testbench
=======================================

# nlfsr_tap_enumerator

Search controller that drives the NLFSR period checker. It enumerates tap-index combinations, presents each on `co_buf`, resets and enables the checker, and waits for `found`, `failure` or a local timeout. Each maximal-period combination is emitted on a valid/ready output. One instance pairs with one checker instance in the search array.

## Interface
Parameters:
- `SIZE`, 11: register length of the paired checker.
- `NUM_OF_TAPS`, 6: number of 8-bit tap fields in `co_buf`. Legal range is 1..SIZE-1.
- `MAX_IDX`, SIZE-1: largest tap index generated.

Ports:
- `clk`  in  1  the single clock.
- `res`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse. Starts a new search; accepted in IDLE or DONE only.
- `found`  in  1  from checker: maximal period reached.
- `failure`  in  1  from checker: period is wrong.
- `chk_res`  out  1  synchronous reset strobe to the checker.
- `chk_ena`  out  1  enable to the checker.
- `co_buf`  out  NUM_OF_TAPS*8  current combination. Field j (1-based) is `co_buf[j*8-1 -: 8]`.
- `hit_valid`  out  1  a maximal combination is presented.
- `hit_ready`  in  1  downstream accepts the hit.
- `hit_taps`  out  NUM_OF_TAPS*8  combination that produced the hit.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  enumeration exhausted. Held until `start` or `res`.
- `tested_cnt`  out  32  number of combinations evaluated.
- `hit_cnt`  out  32  number of hits accepted downstream.

## Operation
- The enumeration covers strictly increasing combinations c1<c2<…<cN with each value in [1, MAX_IDX], in lexicographic order.
- The first combination is cj = j.
- To advance:
  - Find the highest j with cj < MAX_IDX-(N-j).
  - Increment cj, then set ck = c(k-1)+1 for every k>j.
  - If no such j exists, the enumeration is exhausted.
- FSM states:
  - IDLE: on `start`, load the first combination, clear both counters, go to LOAD.
  - LOAD: `chk_res`=1 for exactly one cycle, then go to RUN.
  - RUN: `chk_ena`=1 and the timeout counter increments.
    - `found` → HIT.
    - `failure`, or timeout counter = 2^SIZE+8 → NEXT. A timeout counts as a failure.
    - If `found` and `failure` are both high, failure wins.
  - HIT: `chk_ena`=0. Copy `co_buf` to `hit_taps`, go to EMIT.
  - EMIT: `hit_valid`=1. It stays asserted with stable `hit_taps` until `hit_ready`. On handshake, `hit_cnt`++ and go to NEXT.
  - NEXT: `tested_cnt`++.
    - If exhausted → DONE.
    - Otherwise advance `co_buf` and go to LOAD.
  - DONE: `done`=1. `start` → IDLE behaviour, i.e. restart from the first combination.
- `start` in any busy state is ignored.
- Counters saturate at 2^32-1.

## Timing
- All outputs are registered.
- Reset values:
  - `chk_res`, `chk_ena`, `hit_valid`, `busy`, `done`: 0.
  - `hit_taps`, `tested_cnt`, `hit_cnt`: 0.
  - `co_buf` holds the first combination.
  - FSM is in IDLE.
- Asserting `res` clears everything immediately without a clock edge, including mid-RUN or mid-EMIT. The pending hit is dropped.
- `start` at edge t:
  - `chk_res`=1 during cycle t+1.
  - `chk_ena`=1 from t+2.
- `co_buf` changes only in NEXT. It is stable from LOAD through the end of RUN.
- `chk_ena` deasserts on the cycle after `found`/`failure` is sampled.
- Per-combination overhead, excluding checker run time and downstream stall: LOAD, HIT, EMIT and NEXT, i.e. 4 cycles for a hit and 2 for a failure.
- The timeout counter is 36 bits wide and clears in LOAD.

## Structure
- A shared package `nlfsr_pkg` holds:
  - the FSM state enum;
  - `TAP_W`=8;
  - `TIMEOUT_MARGIN`=8.
- One sub-module, `tap_comb_next`: combinational next-combination logic plus the `exhausted` flag, parameterised by `NUM_OF_TAPS` and `MAX_IDX`.

## Test plan
Checker stub throughout; SIZE=4, NUM_OF_TAPS=2 unless stated.
- Reset: hold `res` → all outputs 0 and `co_buf`=16'h0201. Release with no `start` → remains IDLE.
- Enumeration with stub answering `failure` 10 cycles after `chk_ena` rises:
  - `co_buf` sequence is 16'h0201, 16'h0301, 16'h0302;
  - then `done`=1, `tested_cnt`=3, `hit_cnt`=0.
- Hit with backpressure:
  - stub asserts `found` for 16'h0301;
  - `hit_valid`=1 and `hit_taps`=16'h0301;
  - hold `hit_ready`=0 for 20 cycles → `hit_valid` and `hit_taps` stable, `chk_ena`=0;
  - release → `hit_cnt`=1, next `co_buf`=16'h0302.
- Timeout: stub never answers → `chk_ena` drops after 24 RUN cycles and `co_buf` advances.
- Async reset mid-RUN: assert `res` between clock edges → `chk_ena`, `busy` and counters are 0 before the next edge.
- Restart and ignored start:
  - `start` pulses during RUN → no effect;
  - `start` after DONE → counters clear and `co_buf` returns to 16'h0201.
  - With SIZE=11, NUM_OF_TAPS=6: `tested_cnt` ends at 210.

Source files
------------

// File: rtl/nlfsr_pkg.sv
// rtl/nlfsr_pkg.sv - shared types and constants for the NLFSR tap search
package nlfsr_pkg;

    // Width of one tap-index field in a combination bus.
    localparam int TAP_W = 8;

    // Extra cycles granted beyond the full 2^SIZE period before giving up.
    localparam int TIMEOUT_MARGIN = 8;

    // Enumerator control states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_HIT  = 3'd3,
        ST_EMIT = 3'd4,
        ST_NEXT = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/nlfsr_tap_enumerator_tap_comb_next.sv
// rtl/nlfsr_tap_enumerator_tap_comb_next.sv - lexicographic next-combination logic
module tap_comb_next
    import nlfsr_pkg::*;
#(
    parameter int NUM_OF_TAPS = 6,
    parameter int MAX_IDX     = 10
) (
    input  logic [NUM_OF_TAPS*TAP_W-1:0] cur_comb,
    output logic [NUM_OF_TAPS*TAP_W-1:0] nxt_comb,
    output logic                         exhausted
);

    // Index (1-based) of the field being bumped; 0 means no field can move.
    int pivot;
    logic [TAP_W-1:0] prev;

    // Find the highest field with headroom, bump it and repack everything above it.
    always_comb begin
        pivot = 0;
        for (int j = 1; j <= NUM_OF_TAPS; j++) begin
            // Field j may grow only while the fields above it still fit below MAX_IDX.
            if (int'(cur_comb[j*TAP_W-1 -: TAP_W]) < (MAX_IDX - (NUM_OF_TAPS - j))) begin
                pivot = j;
            end
        end

        exhausted = (pivot == 0);
        nxt_comb  = cur_comb;
        prev      = '0;
        for (int k = 1; k <= NUM_OF_TAPS; k++) begin
            if (pivot != 0 && k == pivot) begin
                nxt_comb[k*TAP_W-1 -: TAP_W] = cur_comb[k*TAP_W-1 -: TAP_W] + TAP_W'(1);
            end else if (pivot != 0 && k > pivot) begin
                nxt_comb[k*TAP_W-1 -: TAP_W] = prev + TAP_W'(1);
            end
            prev = nxt_comb[k*TAP_W-1 -: TAP_W];
        end
    end

endmodule

// File: rtl/nlfsr_tap_enumerator.sv
// rtl/nlfsr_tap_enumerator.sv - tap-combination search controller for one period checker
module nlfsr_tap_enumerator
    import nlfsr_pkg::*;
#(
    parameter int SIZE        = 11,
    parameter int NUM_OF_TAPS = 6,
    parameter int MAX_IDX     = SIZE - 1
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         start,
    input  logic                         found,
    input  logic                         failure,
    output logic                         chk_res,
    output logic                         chk_ena,
    output logic [NUM_OF_TAPS*TAP_W-1:0] co_buf,
    output logic                         hit_valid,
    input  logic                         hit_ready,
    output logic [NUM_OF_TAPS*TAP_W-1:0] hit_taps,
    output logic                         busy,
    output logic                         done,
    output logic [31:0]                  tested_cnt,
    output logic [31:0]                  hit_cnt
);

    localparam int CW = NUM_OF_TAPS * TAP_W;

    // Combination c_j = j, the start of the lexicographic walk.
    function automatic logic [CW-1:0] first_comb();
        logic [CW-1:0] c;
        c = '0;
        for (int j = 1; j <= NUM_OF_TAPS; j++) begin
            c[j*TAP_W-1 -: TAP_W] = TAP_W'(j);
        end
        return c;
    endfunction

    localparam logic [CW-1:0] FIRST_COMB = first_comb();

    // A full period is 2^SIZE steps; a checker silent past this is treated as failed.
    localparam logic [35:0] TIMEOUT_LIMIT = (36'd1 << SIZE) + 36'(TIMEOUT_MARGIN);

    state_e         state_q, state_d;
    logic [CW-1:0]  co_buf_q, co_buf_d;
    logic [CW-1:0]  hit_taps_q, hit_taps_d;
    logic [31:0]    tested_q, tested_d;
    logic [31:0]    hit_cnt_q, hit_cnt_d;
    logic [35:0]    timeout_q, timeout_d;
    logic           chk_res_q, chk_res_d;
    logic           chk_ena_q, chk_ena_d;
    logic           hit_valid_q, hit_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [CW-1:0]  nxt_comb;
    logic           exhausted;

    tap_comb_next #(
        .NUM_OF_TAPS (NUM_OF_TAPS),
        .MAX_IDX     (MAX_IDX)
    ) u_next (
        .cur_comb  (co_buf_q),
        .nxt_comb  (nxt_comb),
        .exhausted (exhausted)
    );

    // State transitions, combination stepping, counters and timeout.
    always_comb begin
        state_d    = state_q;
        co_buf_d   = co_buf_q;
        hit_taps_d = hit_taps_q;
        tested_d   = tested_q;
        hit_cnt_d  = hit_cnt_q;
        timeout_d  = timeout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    co_buf_d  = FIRST_COMB;
                    tested_d  = '0;
                    hit_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                timeout_d = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                timeout_d = timeout_q + 36'd1;
                // Failure (explicit or by timeout) outranks a simultaneous found.
                if (failure || timeout_d == TIMEOUT_LIMIT) begin
                    state_d = ST_NEXT;
                end else if (found) begin
                    state_d = ST_HIT;
                end
            end
            ST_HIT: begin
                hit_taps_d = co_buf_q;
                state_d    = ST_EMIT;
            end
            ST_EMIT: begin
                if (hit_ready) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                    state_d   = ST_NEXT;
                end
            end
            ST_NEXT: begin
                tested_d = sat_inc(tested_q);
                if (exhausted) begin
                    state_d = ST_DONE;
                end else begin
                    co_buf_d = nxt_comb;
                    state_d  = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they are registered yet aligned with it.
    always_comb begin
        chk_res_d   = (state_d == ST_LOAD);
        chk_ena_d   = (state_d == ST_RUN);
        hit_valid_d = (state_d == ST_EMIT);
        done_d      = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    // State and output registers; reset drops any pending hit immediately.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= ST_IDLE;
            co_buf_q    <= FIRST_COMB;
            hit_taps_q  <= '0;
            tested_q    <= '0;
            hit_cnt_q   <= '0;
            timeout_q   <= '0;
            chk_res_q   <= 1'b0;
            chk_ena_q   <= 1'b0;
            hit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            co_buf_q    <= co_buf_d;
            hit_taps_q  <= hit_taps_d;
            tested_q    <= tested_d;
            hit_cnt_q   <= hit_cnt_d;
            timeout_q   <= timeout_d;
            chk_res_q   <= chk_res_d;
            chk_ena_q   <= chk_ena_d;
            hit_valid_q <= hit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign chk_res    = chk_res_q;
    assign chk_ena    = chk_ena_q;
    assign co_buf     = co_buf_q;
    assign hit_valid  = hit_valid_q;
    assign hit_taps   = hit_taps_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign tested_cnt = tested_q;
    assign hit_cnt    = hit_cnt_q;

endmodule

// File: tb/tb_nlfsr_tap_enumerator.sv
// tb/tb_nlfsr_tap_enumerator.sv - self-checking bench for nlfsr_tap_enumerator
module tb_nlfsr_tap_enumerator;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        start = 1'b0;
    logic        hit_ready = 1'b0;
    logic        found, failure;
    logic        chk_res, chk_ena, hit_valid, busy, done;
    logic [15:0] co_buf, hit_taps;
    logic [31:0] tested_cnt, hit_cnt;

    logic        start2 = 1'b0;
    logic        found2, failure2;
    logic        chk_res2, chk_ena2, hit_valid2, busy2, done2;
    logic [47:0] co_buf2, hit_taps2;
    logic [31:0] tested_cnt2, hit_cnt2;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [15:0] exp_q[$];
    logic [1:0]  stub_mode = 2'd0;
    int          run_cyc;
    logic        answer;

    always #5 clk = ~clk;

    nlfsr_tap_enumerator #(.SIZE(4), .NUM_OF_TAPS(2)) dut (
        .clk(clk), .res(res), .start(start), .found(found), .failure(failure),
        .chk_res(chk_res), .chk_ena(chk_ena), .co_buf(co_buf),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_taps(hit_taps),
        .busy(busy), .done(done), .tested_cnt(tested_cnt), .hit_cnt(hit_cnt)
    );

    nlfsr_tap_enumerator #(.SIZE(11), .NUM_OF_TAPS(6)) dut2 (
        .clk(clk), .res(res), .start(start2), .found(found2), .failure(failure2),
        .chk_res(chk_res2), .chk_ena(chk_ena2), .co_buf(co_buf2),
        .hit_valid(hit_valid2), .hit_ready(1'b1), .hit_taps(hit_taps2),
        .busy(busy2), .done(done2), .tested_cnt(tested_cnt2), .hit_cnt(hit_cnt2)
    );

    // Checker stub: answers 10 cycles after enable rises; mode 1 reports 0x0301 as maximal, mode 2 stays silent.
    always @(posedge clk or posedge res) begin
        if (res) run_cyc <= 0;
        else if (chk_ena) run_cyc <= run_cyc + 1;
        else run_cyc <= 0;
    end
    assign answer   = chk_ena && (run_cyc == 10);
    assign found    = answer && (stub_mode == 2'd1) && (co_buf == 16'h0301);
    assign failure  = answer && ((stub_mode == 2'd0) || ((stub_mode == 2'd1) && (co_buf != 16'h0301)));
    assign found2   = 1'b0;
    assign failure2 = chk_ena2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every LOAD strobe must present the next expected combination.
    always @(negedge clk) begin
        if (!res && chk_res) begin
            check("cobuf_expected_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("cobuf_seq", 64'(co_buf), 64'(exp_q.pop_front()));
        end
    end

    task automatic push_seq();
        for (int a = 1; a <= 3; a++)
            for (int b = a + 1; b <= 3; b++)
                exp_q.push_back({8'(b), 8'(a)});
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic wait_ena(input int budget);
        for (int i = 0; i < budget && !chk_ena; i++) @(negedge clk);
        check("ena_reached", 64'(chk_ena), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic bad;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", {chk_res, chk_ena, hit_valid, busy, done}, 64'd0);
        check("rst_cobuf", 64'(co_buf), 64'h0201);
        check("rst_counters", {tested_cnt, hit_cnt}, 64'd0);
        check("rst_hit_taps", 64'(hit_taps), 64'd0);
        res = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_no_start", {chk_res, chk_ena, busy, done}, 64'd0);

        // Plain enumeration with every combination failing
        stub_mode = 2'd0;
        push_seq();
        pulse_start();
        check("start_t1", {chk_res, chk_ena, busy}, 64'b101);
        @(negedge clk);
        check("start_t2", {chk_res, chk_ena}, 64'b01);
        wait_done(500);
        check("enum_tested", 64'(tested_cnt), 64'd3);
        check("enum_hits", 64'(hit_cnt), 64'd0);
        check("enum_drained", 64'(exp_q.size()), 64'd0);
        check("enum_busy", 64'(busy), 64'd0);

        // Hit held off by downstream backpressure
        stub_mode = 2'd1;
        push_seq();
        pulse_start();
        for (int i = 0; i < 300 && !hit_valid; i++) @(negedge clk);
        check("hit_valid", 64'(hit_valid), 64'd1);
        check("hit_taps", 64'(hit_taps), 64'h0301);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hit_valid !== 1'b1 || hit_taps !== 16'h0301 || chk_ena !== 1'b0) bad = 1'b1;
        end
        check("bp_stable", 64'(bad), 64'd0);
        hit_ready = 1'b1;
        @(negedge clk);
        hit_ready = 1'b0;
        check("hs_valid_drop", 64'(hit_valid), 64'd0);
        check("hs_hit_cnt", 64'(hit_cnt), 64'd1);
        @(negedge clk);
        check("after_hit_cobuf", 64'(co_buf), 64'h0302);
        wait_done(500);
        check("hit_run_tested", 64'(tested_cnt), 64'd3);
        check("hit_run_hits", 64'(hit_cnt), 64'd1);

        // Timeout when the checker never answers
        stub_mode = 2'd2;
        push_seq();
        pulse_start();
        wait_ena(10);
        n = 0;
        while (chk_ena && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("timeout_run_cycles", 64'(n), 64'd24);
        wait_done(500);
        check("timeout_tested", 64'(tested_cnt), 64'd3);

        // Asynchronous reset in the middle of a run
        push_seq();
        pulse_start();
        for (int i = 0; i < 200 && tested_cnt == 0; i++) @(negedge clk);
        wait_ena(10);
        repeat (3) @(negedge clk);
        check("pre_reset_tested", 64'(tested_cnt), 64'd1);
        #2 res = 1'b1;
        #1;
        check("async_rst_ctrl", {chk_ena, busy}, 64'd0);
        check("async_rst_cnt", {tested_cnt, hit_cnt}, 64'd0);
        check("async_rst_cobuf", 64'(co_buf), 64'h0201);
        exp_q.delete();
        @(negedge clk) res = 1'b0;

        // Start during RUN is ignored; start after DONE restarts
        stub_mode = 2'd0;
        push_seq();
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        check("ign_start_busy", {busy, chk_ena, chk_res}, 64'b110);
        wait_done(500);
        check("ign_start_tested", 64'(tested_cnt), 64'd3);
        check("ign_start_drained", 64'(exp_q.size()), 64'd0);
        push_seq();
        pulse_start();
        check("restart_cnt", {tested_cnt, hit_cnt}, 64'd0);
        check("restart_cobuf", 64'(co_buf), 64'h0201);
        check("restart_done", 64'(done), 64'd0);
        wait_done(500);
        check("restart_tested", 64'(tested_cnt), 64'd3);

        // Full-size instance: C(10,6) combinations
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        for (int i = 0; i < 5000 && !done2; i++) @(negedge clk);
        check("big_done", 64'(done2), 64'd1);
        check("big_tested", 64'(tested_cnt2), 64'd210);
        check("big_last_cobuf", 64'(co_buf2), 64'h0A0908070605);
        check("big_hits", 64'(hit_cnt2), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
